// File: rtl/lcd_pkg.sv
// lcd_pkg: definitions shared by the LCD bus writer slice.
//   lcd_byte_t     - one queued bus byte: {dcx, data}
//   lcd_wr_state_t - write-strobe sequencer states
//   LCD_CMD/LCD_DATA - dcx encodings (0 = command, 1 = data)
package lcd_pkg;

    localparam logic LCD_CMD  = 1'b0;
    localparam logic LCD_DATA = 1'b1;

    typedef struct packed {
        logic       dcx;
        logic [7:0] data;
    } lcd_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH
    } lcd_wr_state_t;

endpackage

// File: rtl/lcd_bus_writer_if.sv
// lcd_bus_writer_if: producer handshake plus the LCD 8080 write bus.
//   in_valid/in_ready/in_dcx/in_data - byte push handshake
//   busy                             - writer has queued or in-flight work
//   dcx/wr/D                         - LCD data/command select, write strobe, data bus
// master: producer / bus observer side.  slave: the writer.
interface lcd_bus_writer_if;

    logic       in_valid;
    logic       in_ready;
    logic       in_dcx;
    logic [7:0] in_data;
    logic       busy;
    logic       dcx;
    logic       wr;
    logic [7:0] D;

    modport master (
        output in_valid, in_dcx, in_data,
        input  in_ready, busy, dcx, wr, D
    );

    modport slave (
        input  in_valid, in_dcx, in_data,
        output in_ready, busy, dcx, wr, D
    );

endinterface

// File: rtl/lcd_byte_fifo.sv
// lcd_byte_fifo: synchronous FIFO of lcd_byte_t.
//   hwclk, nrst - clock, synchronous active-low reset (clears pointers)
//   push, wdata - write a byte (ignored when full)
//   pop         - drop the head byte (ignored when empty)
//   full, empty - occupancy flags
//   head        - combinational view of the oldest byte
module lcd_byte_fifo
    import lcd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic      hwclk,
    input  logic      nrst,
    input  logic      push,
    input  lcd_byte_t wdata,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output lcd_byte_t head
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    // Pointers carry one wrap bit above the address so full and empty differ.
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    lcd_byte_t   mem [FIFO_DEPTH];

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    always_ff @(posedge hwclk) begin
        if (push && !full) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge hwclk) begin
        if (!nrst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) begin
                wptr <= wptr + 1'b1;
            end
            if (pop && !empty) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: drains queued {dcx, data} bytes onto an 8080-style LCD bus.
//   hwclk - system clock (rising edge)
//   nrst  - synchronous active-low reset
//   bus   - slave side of lcd_bus_writer_if: producer handshake in,
//           busy and registered dcx/wr/D out
// Each byte takes 1 setup cycle (wr high, D valid), WR_LOW_CYCLES with wr
// low, then WR_HIGH_CYCLES with wr high and D held; the next byte is popped
// straight out of HIGH so back-to-back bytes keep a 1+L+H cycle period.
module lcd_bus_writer
    import lcd_pkg::*;
#(
    parameter int unsigned WR_LOW_CYCLES  = 2,
    parameter int unsigned WR_HIGH_CYCLES = 2,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic               hwclk,
    input  logic               nrst,
    lcd_bus_writer_if.slave    bus
);

    localparam int unsigned LW = $clog2(WR_LOW_CYCLES) + 1;
    localparam int unsigned HW = $clog2(WR_HIGH_CYCLES) + 1;
    localparam logic [LW-1:0] LOW_LAST  = LW'(WR_LOW_CYCLES - 1);
    localparam logic [HW-1:0] HIGH_LAST = HW'(WR_HIGH_CYCLES - 1);

    lcd_wr_state_t state;
    logic [LW-1:0] low_cnt;
    logic [HW-1:0] high_cnt;
    logic          accept_en;
    logic          wr_q;
    logic          dcx_q;
    logic [7:0]    d_q;

    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    lcd_byte_t     push_byte;
    lcd_byte_t     head;

    // accept_en is cleared by reset so in_ready only rises on the first
    // edge after release; nrst also gates it directly while held low.
    assign bus.in_ready   = nrst & accept_en & ~full;
    assign push           = bus.in_valid & bus.in_ready;
    assign push_byte.dcx  = bus.in_dcx;
    assign push_byte.data = bus.in_data;

    assign pop = ~empty & ((state == IDLE) ||
                           ((state == HIGH) && (high_cnt == HIGH_LAST)));

    assign bus.busy = ~empty | (state != IDLE);
    assign bus.wr   = wr_q;
    assign bus.dcx  = dcx_q;
    assign bus.D    = d_q;

    lcd_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .hwclk (hwclk),
        .nrst  (nrst),
        .push  (push),
        .wdata (push_byte),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_ff @(posedge hwclk) begin
        if (!nrst) begin
            state     <= IDLE;
            low_cnt   <= '0;
            high_cnt  <= '0;
            accept_en <= 1'b0;
            wr_q      <= 1'b1;
            dcx_q     <= LCD_DATA;
            d_q       <= '0;
        end else begin
            accept_en <= 1'b1;
            case (state)
                IDLE: begin
                    wr_q <= 1'b1;
                    if (pop) begin
                        d_q   <= head.data;
                        dcx_q <= head.dcx;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    wr_q    <= 1'b0;
                    low_cnt <= '0;
                    state   <= LOW;
                end
                LOW: begin
                    if (low_cnt == LOW_LAST) begin
                        wr_q     <= 1'b1;
                        low_cnt  <= '0;
                        high_cnt <= '0;
                        state    <= HIGH;
                    end else begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (high_cnt == HIGH_LAST) begin
                        high_cnt <= '0;
                        if (pop) begin
                            d_q   <= head.data;
                            dcx_q <= head.dcx;
                            state <= SETUP;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        high_cnt <= high_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// tb_lcd_bus_writer: self-checking bench for lcd_bus_writer.
// dut0 uses default timing (L=2, H=2); dut1 uses L=1, H=3.
// A timing model derives every byte's pop edge from its accept edge
// (pop = max(accept+1, previous pop + 1+L+H)) and from that the expected
// bus state on every cycle; directed tests add literal expectations.
module tb_lcd_bus_writer;

    localparam int DEPTH = 4;

    logic tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    logic [1:0]      nrst_s  = 2'b00;
    logic [1:0]      s_valid = 2'b00;
    logic [1:0]      s_dcx   = 2'b00;
    logic [1:0][7:0] s_data  = '0;

    logic [1:0]      o_wr, o_dcx, o_busy, o_rdy;
    logic [1:0][7:0] o_d;

    lcd_bus_writer_if bus0();
    lcd_bus_writer_if bus1();

    assign bus0.in_valid = s_valid[0];
    assign bus0.in_dcx   = s_dcx[0];
    assign bus0.in_data  = s_data[0];
    assign bus1.in_valid = s_valid[1];
    assign bus1.in_dcx   = s_dcx[1];
    assign bus1.in_data  = s_data[1];

    assign o_wr   = {bus1.wr,       bus0.wr};
    assign o_dcx  = {bus1.dcx,      bus0.dcx};
    assign o_busy = {bus1.busy,     bus0.busy};
    assign o_rdy  = {bus1.in_ready, bus0.in_ready};
    assign o_d    = {bus1.D,        bus0.D};

    lcd_bus_writer #(
        .WR_LOW_CYCLES  (2),
        .WR_HIGH_CYCLES (2),
        .FIFO_DEPTH     (DEPTH)
    ) dut0 (
        .hwclk (tb_clk),
        .nrst  (nrst_s[0]),
        .bus   (bus0)
    );

    lcd_bus_writer #(
        .WR_LOW_CYCLES  (1),
        .WR_HIGH_CYCLES (3),
        .FIFO_DEPTH     (DEPTH)
    ) dut1 (
        .hwclk (tb_clk),
        .nrst  (nrst_s[1]),
        .bus   (bus1)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int Lp [2] = '{2, 1};
    int Hp [2] = '{2, 3};

    // model records: accept edge, pop edge, {dcx,data}
    int m_n [2];
    int m_a [2][64];
    int m_p [2][64];
    int m_b [2][64];
    bit m_rdy    [2];
    bit seen_rst [2];
    bit acc_last [2];
    int acc_total [2];
    int acc_cyc   [2][64];
    int np;

    // bus monitor: strobe falling/rising edges and the byte under each strobe
    int fall_cnt  [2];
    int fall_cyc  [2][32];
    int rise_cyc  [2][32];
    int fall_byte [2][32];
    logic [1:0] prev_wr = 2'b11;

    int ewr_seq  [6] = '{1, 0, 0, 1, 1, 1};
    int ebsy_seq [6] = '{1, 1, 1, 1, 1, 0};
    int eacc_seq [6] = '{0, 1, 2, 3, 4, 7};

    task automatic check(input string name, input int idx, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=0x%0h expected=0x%0h", name, idx, cyc, got, exp);
        end
    endtask

    function automatic int period(input int k);
        return 1 + Lp[k] + Hp[k];
    endfunction

    function automatic int fifo_cnt(input int k, input int n);
        int c = 0;
        for (int i = 0; i < m_n[k]; i++) begin
            if (m_a[k][i] <= n && n < m_p[k][i]) c++;
        end
        return c;
    endfunction

    function automatic int last_pop(input int k, input int n);
        int li = -1;
        for (int i = 0; i < m_n[k]; i++) begin
            if (m_p[k][i] <= n) li = i;
        end
        return li;
    endfunction

    function automatic int busy_exp(input int k, input int n);
        for (int i = 0; i < m_n[k]; i++) begin
            if (m_a[k][i] <= n && n < m_p[k][i] + period(k)) return 1;
        end
        return 0;
    endfunction

    // model update on every rising edge, from inputs as they stood before it
    always @(posedge tb_clk) begin
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            acc_last[k] = 1'b0;
            if (!nrst_s[k]) begin
                m_n[k]      = 0;
                m_rdy[k]    = 1'b0;
                seen_rst[k] = 1'b1;
            end else begin
                if (s_valid[k] && m_rdy[k] && fifo_cnt(k, cyc - 1) < DEPTH && m_n[k] < 64) begin
                    np = cyc + 1;
                    if (m_n[k] > 0 && m_p[k][m_n[k]-1] + period(k) > np)
                        np = m_p[k][m_n[k]-1] + period(k);
                    m_a[k][m_n[k]] = cyc;
                    m_p[k][m_n[k]] = np;
                    m_b[k][m_n[k]] = {23'd0, s_dcx[k], s_data[k]};
                    m_n[k]++;
                    acc_last[k] = 1'b1;
                    if (acc_total[k] < 64) acc_cyc[k][acc_total[k]] = cyc;
                    acc_total[k]++;
                end
                m_rdy[k] = 1'b1;
            end
        end
    end

    // compare process: every cycle, both DUTs, against the model
    always @(negedge tb_clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (seen_rst[k]) begin
                automatic int li  = last_pop(k, cyc);
                automatic int ed  = (li < 0) ? 0 : (m_b[k][li] & 8'hFF);
                automatic int edc = (li < 0) ? 1 : ((m_b[k][li] >> 8) & 1);
                automatic int ewr = (li >= 0 && cyc >= m_p[k][li] + 1 &&
                                     cyc < m_p[k][li] + 1 + Lp[k]) ? 0 : 1;
                automatic int erd = (nrst_s[k] && m_rdy[k] && fifo_cnt(k, cyc) < DEPTH) ? 1 : 0;
                check("model_wr",    k, int'(o_wr[k]),   ewr);
                check("model_D",     k, int'(o_d[k]),    ed);
                check("model_dcx",   k, int'(o_dcx[k]),  edc);
                check("model_busy",  k, int'(o_busy[k]), busy_exp(k, cyc));
                check("model_ready", k, int'(o_rdy[k]),  erd);
                if (prev_wr[k] && !o_wr[k] && fall_cnt[k] < 32) begin
                    fall_cyc[k][fall_cnt[k]]  = cyc;
                    fall_byte[k][fall_cnt[k]] = {23'd0, o_dcx[k], o_d[k]};
                    fall_cnt[k]++;
                end
                if (!prev_wr[k] && o_wr[k] && fall_cnt[k] > 0)
                    rise_cyc[k][fall_cnt[k]-1] = cyc;
                prev_wr[k] = o_wr[k];
            end
        end
    end

    // hold in_valid until nb bytes base, base+1, ... are taken
    task automatic stream(input int idx, input int nb, input logic dcxv, input logic [7:0] base);
        int k = 0;
        int guard = 0;
        s_valid[idx] = 1'b1;
        s_dcx[idx]   = dcxv;
        s_data[idx]  = base;
        while (k < nb && guard < 200) begin
            @(negedge tb_clk);
            guard++;
            if (acc_last[idx]) begin
                k++;
                s_data[idx] = base + 8'(k);
            end
        end
        s_valid[idx] = 1'b0;
        check("stream_accepted", idx, k, nb);
    endtask

    initial begin
        int fb, ab, wl;

        // reset
        repeat (2) @(posedge tb_clk);
        @(negedge tb_clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_wr",    k, int'(o_wr[k]),   1);
            check("rst_dcx",   k, int'(o_dcx[k]),  1);
            check("rst_D",     k, int'(o_d[k]),    0);
            check("rst_busy",  k, int'(o_busy[k]), 0);
            check("rst_ready", k, int'(o_rdy[k]),  0);
        end
        nrst_s = 2'b11;
        #1;
        check("ready_at_release", 0, int'(o_rdy[0]), 0);
        @(negedge tb_clk);
        check("ready_after_edge", 0, int'(o_rdy[0]), 1);
        check("ready_after_edge", 1, int'(o_rdy[1]), 1);

        // single command byte 0x2C
        s_valid[0] = 1'b1;
        s_dcx[0]   = 1'b0;
        s_data[0]  = 8'h2C;
        @(negedge tb_clk);
        s_valid[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge tb_clk);
            check("single_wr",   0, int'(o_wr[0]),   ewr_seq[i]);
            check("single_busy", 0, int'(o_busy[0]), ebsy_seq[i]);
            check("single_D",    0, int'(o_d[0]),    8'h2C);
            check("single_dcx",  0, int'(o_dcx[0]),  0);
        end

        // burst of 4 data bytes
        repeat (3) @(negedge tb_clk);
        fb = fall_cnt[0];
        stream(0, 4, 1'b1, 8'hA0);
        repeat (30) @(negedge tb_clk);
        check("burst_pulses", 0, fall_cnt[0] - fb, 4);
        for (int i = 0; i < 4; i++) begin
            check("burst_byte", 0, fall_byte[0][fb+i], 9'h1A0 + i);
            check("burst_low",  0, rise_cyc[0][fb+i] - fall_cyc[0][fb+i], 2);
            if (i < 3) begin
                check("burst_spacing", 0, fall_cyc[0][fb+i+1] - fall_cyc[0][fb+i], 5);
                check("burst_high",    0, fall_cyc[0][fb+i+1] - rise_cyc[0][fb+i], 3);
            end
        end

        // full FIFO: 6 bytes offered continuously
        fb = fall_cnt[0];
        ab = acc_total[0];
        stream(0, 6, 1'b1, 8'hB0);
        repeat (40) @(negedge tb_clk);
        for (int i = 0; i < 6; i++)
            check("full_accept_edge", 0, acc_cyc[0][ab+i] - acc_cyc[0][ab], eacc_seq[i]);
        check("full_pulses", 0, fall_cnt[0] - fb, 6);
        for (int i = 0; i < 6; i++)
            check("full_byte", 0, fall_byte[0][fb+i], 9'h1B0 + i);

        // reset while wr is low
        fb = fall_cnt[0];
        stream(0, 3, 1'b1, 8'hC0);
        wl = 0;
        while (o_wr[0] && wl < 20) begin
            @(negedge tb_clk);
            wl++;
        end
        check("wait_wr_low", 0, int'(o_wr[0]), 0);
        nrst_s[0] = 1'b0;
        @(negedge tb_clk);
        check("midrst_wr",    0, int'(o_wr[0]),   1);
        check("midrst_busy",  0, int'(o_busy[0]), 0);
        check("midrst_ready", 0, int'(o_rdy[0]),  0);
        check("midrst_D",     0, int'(o_d[0]),    0);
        @(negedge tb_clk);
        nrst_s[0] = 1'b1;
        repeat (30) @(negedge tb_clk);
        check("midrst_pulses", 0, fall_cnt[0] - fb, 1);
        check("midrst_idle",   0, int'(o_busy[0]), 0);

        // L=1, H=3 instance
        fb = fall_cnt[1];
        stream(1, 4, 1'b1, 8'hE0);
        repeat (30) @(negedge tb_clk);
        check("lh_pulses", 1, fall_cnt[1] - fb, 4);
        for (int i = 0; i < 4; i++) begin
            check("lh_byte", 1, fall_byte[1][fb+i], 9'h1E0 + i);
            check("lh_low",  1, rise_cyc[1][fb+i] - fall_cyc[1][fb+i], 1);
            if (i < 3) begin
                check("lh_spacing", 1, fall_cyc[1][fb+i+1] - fall_cyc[1][fb+i], 5);
                check("lh_high",    1, fall_cyc[1][fb+i+1] - rise_cyc[1][fb+i], 4);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
